// File: rtl/serial_word_assembler.sv
// -----------------------------------------------------------------------------
// serial_word_assembler
//
// Collects one serial bit per enabled clock edge and packs WIDTH bits into a
// parallel word. Each completed word is held in an output register and offered
// through a valid/ready handshake. If a word completes while the held word is
// still unconsumed, the new word is dropped and a sticky overrun flag is set.
//
// Ports
//   clk         in   1      single clock, rising edge
//   rst         in   1      synchronous active-high reset
//   sin         in   1      serial data bit
//   sin_en      in   1      sin is valid on this edge
//   frame       in   1      word-alignment strobe, restarts assembly at bit 0
//   dout        out  WIDTH  last completed word
//   dout_valid  out  1      dout holds an unconsumed word
//   dout_ready  in   1      consumer accepts dout (only looked at while valid)
//   overrun     out  1      sticky: a completed word was dropped
//   ovr_clr     in   1      clears overrun (a new overrun on the same edge wins)
//   bit_cnt     out  CNT_W  bits collected in the current partial word
//
// Parameters
//   WIDTH      bits per word, 2..32
//   MSB_FIRST  1: first bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0]
//   CNT_W      width of bit_cnt, 2**CNT_W must exceed WIDTH
//
// Holding FSM
//   state | meaning
//   EMPTY | no word held, dout_valid = 0 (dout may carry a stale word)
//   FULL  | dout holds an unconsumed word, dout_valid = 1
// -----------------------------------------------------------------------------
module serial_word_assembler #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             frame,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state;

  // Only WIDTH-1 bits of history are ever needed: the WIDTH-th bit goes
  // straight into the word and the partial register is cleared on that edge.
  // MSB_FIRST=1 keeps the partial right-aligned (newest bit at [0]);
  // MSB_FIRST=0 keeps it left-aligned (newest bit at [WIDTH-2]).
  logic [WIDTH-2:0] sreg;

  logic [WIDTH-1:0] shifted;      // partial word with the current sin appended
  logic [WIDTH-2:0] shift_part;   // partial register after a normal shift
  logic [WIDTH-2:0] entry_part;   // partial register holding only sin (frame edge)
  logic             complete;     // this edge samples the last bit of a word
  logic             drop;         // completed word cannot be stored

  always_comb begin
    shifted    = '0;
    shift_part = '0;
    entry_part = '0;
    if (MSB_FIRST) begin
      shifted       = {sreg, sin};
      shift_part    = shifted[WIDTH-2:0];
      entry_part[0] = sin;
    end else begin
      shifted             = {sin, sreg};
      shift_part          = shifted[WIDTH-1:1];
      entry_part[WIDTH-2] = sin;
    end
  end

  // A frame edge always restarts assembly, so it can never complete a word.
  assign complete = sin_en && !frame && (bit_cnt == LAST_BIT);
  assign drop     = (state == FULL) && complete && !dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      state      <= EMPTY;
    end else begin
      // ---------------- assembly ----------------
      if (frame) begin
        if (sin_en) begin
          sreg    <= entry_part;
          bit_cnt <= CNT_ONE;
        end else begin
          sreg    <= '0;
          bit_cnt <= '0;
        end
      end else if (sin_en) begin
        if (complete) begin
          sreg    <= '0;
          bit_cnt <= '0;
        end else begin
          sreg    <= shift_part;
          bit_cnt <= bit_cnt + CNT_ONE;
        end
      end

      // ---------------- holding FSM ----------------
      case (state)
        EMPTY: begin
          if (complete) begin
            dout       <= shifted;
            dout_valid <= 1'b1;
            state      <= FULL;
          end
        end
        FULL: begin
          if (complete) begin
            // Consumer takes the old word on this edge, so the slot is free
            // for the new one; otherwise the new word is lost.
            if (dout_ready) begin
              dout <= shifted;
            end
          end else if (dout_ready) begin
            dout_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        default: begin
          dout_valid <= 1'b0;
          state      <= EMPTY;
        end
      endcase

      // ---------------- overrun ----------------
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_assembler.sv
// -----------------------------------------------------------------------------
// tb_serial_word_assembler
//
// Drives two instances (MSB-first and LSB-first, WIDTH=8) from shared inputs.
// A behavioural model keeps the bits of the partial word in a queue and builds
// completed words by placing each bit at its position; a per-cycle compare
// process checks both instances against it. Directed sequences add literal
// expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_serial_word_assembler;

  localparam int WIDTH = 8;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst, sin, sin_en, frame, dout_ready, ovr_clr;
  logic [WIDTH-1:0] dout_m, dout_l;
  logic             valid_m, valid_l, ovr_m, ovr_l;
  logic [CNT_W-1:0] cnt_m, cnt_l;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  serial_word_assembler #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .CNT_W(CNT_W)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .frame(frame),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .overrun(ovr_m), .ovr_clr(ovr_clr), .bit_cnt(cnt_m)
  );

  serial_word_assembler #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .CNT_W(CNT_W)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .frame(frame),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .overrun(ovr_l), .ovr_clr(ovr_clr), .bit_cnt(cnt_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit               q_bits[$];
  logic [WIDTH-1:0] m_dout_m = '0;
  logic [WIDTH-1:0] m_dout_l = '0;
  bit               m_valid  = 1'b0;
  bit               m_ovr    = 1'b0;

  always @(posedge clk) begin
    bit               done;
    logic [WIDTH-1:0] wm, wl;
    done = 1'b0;
    wm   = '0;
    wl   = '0;
    if (rst) begin
      q_bits.delete();
      m_dout_m = '0;
      m_dout_l = '0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
    end else begin
      if (frame) begin
        q_bits.delete();
        if (sin_en) q_bits.push_back(sin);
      end else if (sin_en) begin
        q_bits.push_back(sin);
        if (q_bits.size() == WIDTH) begin
          done = 1'b1;
          for (int i = 0; i < WIDTH; i++) begin
            wm[WIDTH-1-i] = q_bits[i];
            wl[i]         = q_bits[i];
          end
          q_bits.delete();
        end
      end
      if (done && m_valid && !dout_ready) begin
        m_ovr = 1'b1;
      end else begin
        if (ovr_clr) m_ovr = 1'b0;
        if (done) begin
          m_dout_m = wm;
          m_dout_l = wl;
          m_valid  = 1'b1;
        end else if (m_valid && dout_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("msb_dout",    32'(dout_m),  32'(m_dout_m));
      chk("msb_valid",   32'(valid_m), 32'(m_valid));
      chk("msb_overrun", 32'(ovr_m),   32'(m_ovr));
      chk("msb_bit_cnt", 32'(cnt_m),   32'(q_bits.size()));
      chk("lsb_dout",    32'(dout_l),  32'(m_dout_l));
      chk("lsb_valid",   32'(valid_l), 32'(m_valid));
      chk("lsb_overrun", 32'(ovr_l),   32'(m_ovr));
      chk("lsb_bit_cnt", 32'(cnt_l),   32'(q_bits.size()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic s, input logic en, input logic fr,
                       input logic rdy, input logic clr, input logic r);
    @(negedge clk);
    sin        = s;
    sin_en     = en;
    frame      = fr;
    dout_ready = rdy;
    ovr_clr    = clr;
    rst        = r;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic rdy_last);
    for (int i = 7; i >= 0; i--)
      drive(v[i], 1'b1, 1'b0, (i == 0) ? rdy_last : 1'b0, 1'b0, 1'b0);
  endtask

  // Wait for the edge that samples the last driven inputs, then settle.
  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
  endtask

  task automatic chk_both(input string name, input logic [7:0] em, input logic [7:0] el,
                          input logic ev, input logic eo, input logic [CNT_W-1:0] ec);
    chk({name, "_dout_m"},  32'(dout_m),  32'(em));
    chk({name, "_dout_l"},  32'(dout_l),  32'(el));
    chk({name, "_valid"},   32'(valid_m), 32'(ev));
    chk({name, "_overrun"}, 32'(ovr_m),   32'(eo));
    chk({name, "_bit_cnt"}, 32'(cnt_m),   32'(ec));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] a5;
    sin = 0; sin_en = 0; frame = 0; dout_ready = 0; ovr_clr = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk_both("reset", 8'h00, 8'h00, 1'b0, 1'b0, '0);
    idle();

    // 1,0,1,1,0,0,1,0: MSB-first 0xB2, LSB-first 0x4D
    send_byte(8'hB2, 1'b0);
    sample();
    chk_both("first_word", 8'hB2, 8'h4D, 1'b1, 1'b0, '0);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    chk_both("consumed", 8'hB2, 8'h4D, 1'b0, 1'b0, '0);
    idle();

    // overrun, clear, then replace-on-ready
    send_byte(8'hB2, 1'b0);
    send_byte(8'hFF, 1'b0);
    sample();
    chk_both("overrun_set", 8'hB2, 8'h4D, 1'b1, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    chk_both("overrun_clr", 8'hB2, 8'h4D, 1'b1, 1'b0, '0);
    send_byte(8'hFF, 1'b1);
    sample();
    chk_both("replace_on_ready", 8'hFF, 8'hFF, 1'b1, 1'b0, '0);
    consume();

    // frame restart mid-word
    for (int i = 0; i < 5; i++) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("pre_frame_bit_cnt", 32'(cnt_m), 32'd5);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    chk("post_frame_bit_cnt", 32'(cnt_l), 32'd1);
    for (int i = 0; i < 7; i++) drive((i == 6), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk_both("frame_word", 8'h81, 8'h81, 1'b1, 1'b0, '0);
    consume();

    // alternating sin_en carrying 0xA5
    a5 = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      else            drive(a5[7 - i / 2], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    sample();
    chk_both("gapped_word", 8'hA5, 8'hA5, 1'b1, 1'b0, '0);
    consume();

    // reset while FULL with overrun set and a partial word in flight
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk_both("pre_reset", 8'h11, 8'h88, 1'b1, 1'b1, CNT_W'(4));
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    sample();
    chk_both("mid_reset", 8'h00, 8'h00, 1'b0, 1'b0, '0);
    idle();
    send_byte(8'h3C, 1'b0);
    sample();
    chk_both("after_reset", 8'h3C, 8'h3C, 1'b1, 1'b0, '0);
    idle();

    // randomized phase, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 75),
            ($urandom_range(0, 99) < 4),
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 999) < 5));
    end
    idle();
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
